// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC front end: codeword geometry and the issue FSM encoding.
// The frame loader and the decoder both import this package.
package ldpc_pkg;

    localparam int DATA_W  = 32;
    localparam int FRAME_W = 256;
    localparam int BEATS   = FRAME_W / DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_FREE = 2'd3
    } issue_state_e;

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Small FIFO of complete codewords between the beat assembler and the issue FSM.
// The head entry is visible combinationally so the loader can register it into tx.
module frame_fifo
    import ldpc_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            wr_d = (wr_q == LAST_SLOT) ? '0 : wr_q + 1'b1;
        end
        if (pop_i) begin
            rd_d = (rd_q == LAST_SLOT) ? '0 : rd_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/frame_loader.sv
// Assembles DATA_W beats into FRAME_W codewords, buffers complete frames and
// hands them one at a time to the decoder with a single-cycle work pulse.
module frame_loader #(
    parameter int DATA_W  = ldpc_pkg::DATA_W,
    parameter int FRAME_W = ldpc_pkg::FRAME_W,
    parameter int DEPTH   = 2,
    parameter int BUSY_TO = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    input  logic                         dec_free,
    output logic                         work,
    output logic [FRAME_W-1:0]           tx,
    output logic                         frame_err,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    import ldpc_pkg::*;

    localparam int BEATS = FRAME_W / DATA_W;
    localparam int CNT_W = cnt_width(BEATS);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int TMR_W = cnt_width(BUSY_TO);
    localparam int ASM_W = FRAME_W - DATA_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if ((FRAME_W % DATA_W) != 0 || BEATS < 2) begin : g_bad_geometry
            $error("frame_loader: FRAME_W must be an integer multiple (>= 2) of DATA_W");
        end
        if (DEPTH < 1 || BUSY_TO < 1) begin : g_bad_sizing
            $error("frame_loader: DEPTH and BUSY_TO must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ASM_W-1:0]   asm_q;
    logic               err_q, err_d;
    issue_state_e       state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] push_frame;
    logic [FRAME_W-1:0] head;
    logic [OCC_W-1:0]   occ;
    logic               at_last;
    logic               accept;
    logic               push;
    logic               pop;

    // Back-pressure only on the beat that would need a free slot; a pop in the
    // same cycle is deliberately ignored to keep s_ready off the FSM path.
    assign at_last = (cnt_q == LAST_BEAT);
    assign s_ready = !(at_last && (occ == OCC_W'(DEPTH)));
    assign accept  = s_valid && s_ready;
    assign push    = accept && at_last && s_last;

    // The final beat goes straight into the FIFO, so only BEATS-1 beats are held.
    assign push_frame = {s_data, asm_q};

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (accept) begin
            if (at_last || s_last) begin
                cnt_d = '0;
                err_d = at_last ^ s_last;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !at_last) begin
            asm_q[cnt_q*DATA_W +: DATA_W] <= s_data;
        end
    end

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_frame),
        .head_o  (head),
        .count_o (occ)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((occ != '0) && dec_free) begin
                    state_d = ST_ISSUE;
                    tx_d    = head;
                end
            end
            ST_ISSUE: begin
                pop     = 1'b1;
                tmr_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A decoder that never drops dec_free is assumed to have missed
                // the pulse or finished instantly; give up after BUSY_TO cycles.
                if (!dec_free) begin
                    state_d = ST_WAIT_FREE;
                end else if (tmr_q == TMR_W'(BUSY_TO - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT_FREE: begin
                if (dec_free) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            tx_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            tx_q    <= tx_d;
        end
    end

    assign work      = (state_q == ST_ISSUE);
    assign tx        = tx_q;
    assign frame_err = err_q;
    assign occupancy = occ;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: a per-cycle vector table followed by
// hand-written back-pressure, decoder-handshake and reset sequences.
module tb_frame_loader;

    localparam int DW    = 32;
    localparam int FW    = 256;
    localparam int BT    = FW / DW;
    localparam int DEPTH = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          s_valid  = 1'b0;
    logic [DW-1:0] s_data   = '0;
    logic          s_last   = 1'b0;
    logic          dec_free = 1'b0;
    logic          s_ready;
    logic          work;
    logic [FW-1:0] tx;
    logic          frame_err;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    frame_loader #(
        .DATA_W  (DW),
        .FRAME_W (FW),
        .DEPTH   (DEPTH),
        .BUSY_TO (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .dec_free  (dec_free),
        .work      (work),
        .tx        (tx),
        .frame_err (frame_err),
        .occupancy (occupancy)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          f;
        logic          e_rdy;
        logic          e_work;
        logic          e_err;
        logic [1:0]    e_occ;
        logic          chk_tx;
        logic [FW-1:0] e_tx;
    } vec_t;

    vec_t          vecs[$];
    logic [FW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            work_cnt = 0;
    int            last_work_cyc = -100;
    int            work_gap = 0;
    int            busy = 0;
    bit            mon_en = 0;
    bit            dec_auto = 0;
    logic          prev_work = 1'b0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock step; also runs the work-pulse scoreboard and the decoder model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en && work) begin
            check("no_back_to_back_work", prev_work, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_work: got work=1 at cycle %0d expected no pending frame", cyc);
            end else begin
                check("tx_order", tx, exp_q.pop_front());
            end
            work_cnt++;
            work_gap      = cyc - last_work_cyc;
            last_work_cyc = cyc;
        end
        prev_work = work;
        if (dec_auto) begin
            if (work) begin
                busy     = 40;
                dec_free = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) dec_free = 1'b1;
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && guard < 5000) begin
            tick();
            guard++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got s_ready=0 for %0d cycles expected 1", guard);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f);
        for (int k = 0; k < BT; k++) send_beat(f[k*DW +: DW], k == BT - 1);
        exp_q.push_back(f);
    endtask

    task automatic wait_works(input int target, input int budget, input string name);
        int n = 0;
        while (work_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, work_cnt, target);
    endtask

    task automatic addv(input logic v, input logic [DW-1:0] d, input logic l, input logic f,
                        input logic e_work, input logic e_err, input logic [1:0] e_occ,
                        input logic chk_tx, input logic [FW-1:0] e_tx);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.f = f;
        t.e_rdy = 1'b1; t.e_work = e_work; t.e_err = e_err; t.e_occ = e_occ;
        t.chk_tx = chk_tx; t.e_tx = e_tx;
        vecs.push_back(t);
    endtask

    initial begin
        logic [FW-1:0] f1, f2, fa, fb, fc, fr;
        int n0;

        for (int k = 0; k < BT; k++) begin
            f1[k*DW +: DW] = DW'(k);
            f2[k*DW +: DW] = DW'(32'h100 + k);
            fa[k*DW +: DW] = DW'(32'hA000 + k);
            fb[k*DW +: DW] = DW'(32'hB000 + k);
            fc[k*DW +: DW] = DW'(32'hC000 + k);
        end

        // Well-formed frame, issued two cycles after its last beat.
        for (int k = 0; k < BT; k++) addv(1, DW'(k), k == BT-1, 1, 0, 0, (k == BT-1) ? 2'd1 : 2'd0, 0, '0);
        addv(0, '0, 0, 1, 1, 0, 2'd1, 1, f1);
        addv(0, '0, 0, 1, 0, 0, 2'd0, 1, f1);
        // Early s_last on beat 3.
        for (int k = 0; k < 4; k++) addv(1, DW'(32'hA0 + k), k == 3, 1, 0, k == 3, 2'd0, 0, '0);
        addv(0, '0, 0, 1, 0, 0, 2'd0, 0, '0);
        for (int k = 0; k < BT; k++) addv(1, DW'(32'h100 + k), k == BT-1, 1, 0, 0, (k == BT-1) ? 2'd1 : 2'd0, 0, '0);
        addv(0, '0, 0, 1, 1, 0, 2'd1, 1, f2);
        addv(0, '0, 0, 1, 0, 0, 2'd0, 1, f2);
        // Missing s_last on the final beat.
        for (int k = 0; k < BT; k++) addv(1, DW'(32'h200 + k), 0, 1, 0, k == BT-1, 2'd0, 0, '0);
        addv(0, '0, 0, 1, 0, 0, 2'd0, 1, f2);

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_work", work, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_tx", tx, '0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            s_valid  = vecs[i].v;
            s_data   = vecs[i].d;
            s_last   = vecs[i].l;
            dec_free = vecs[i].f;
            tick();
            check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_work", i), work, vecs[i].e_work);
            check($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].e_err);
            check($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
            if (vecs[i].chk_tx) check($sformatf("vec%0d_tx", i), tx, vecs[i].e_tx);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;

        // Decoder never drops dec_free: second frame follows after the busy timeout.
        mon_en   = 1;
        dec_free = 1'b0;
        send_frame(fa);
        send_frame(fb);
        check("timeout_occ_full", occupancy, 2'd2);
        dec_free = 1'b1;
        n0 = work_cnt;
        wait_works(n0 + 2, 40, "timeout_two_works");
        check("timeout_work_gap", work_gap, 6);
        for (int i = 0; i < 8; i++) tick();
        check("timeout_occ_empty", occupancy, 2'd0);

        // Back-pressure with a stalled decoder, then release.
        dec_free = 1'b0;
        n0 = work_cnt;
        send_frame(fa);
        send_frame(fb);
        for (int k = 0; k < BT - 1; k++) send_beat(fc[k*DW +: DW], 1'b0);
        s_valid = 1'b1;
        s_data  = fc[(BT-1)*DW +: DW];
        s_last  = 1'b1;
        tick();
        check("stall_s_ready", s_ready, 1'b0);
        check("stall_occ", occupancy, 2'd2);
        tick();
        check("stall_s_ready_hold", s_ready, 1'b0);
        busy     = 0;
        dec_free = 1'b1;
        dec_auto = 1;
        send_beat(fc[(BT-1)*DW +: DW], 1'b1);
        exp_q.push_back(fc);
        wait_works(n0 + 3, 500, "stall_three_works");
        check("stall_queue_drained", exp_q.size(), 0);

        // Random frames against the 40-cycle-busy decoder model.
        n0 = work_cnt;
        for (int fi = 0; fi < 100; fi++) begin
            for (int k = 0; k < BT; k++) fr[k*DW +: DW] = $urandom;
            send_frame(fr);
        end
        wait_works(n0 + 100, 2000, "random_work_count");
        check("random_queue_drained", exp_q.size(), 0);

        // Reset mid-frame with one frame buffered.
        dec_auto = 0;
        dec_free = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        send_frame(fa);
        check("midrst_buffered", occupancy, 2'd1);
        for (int k = 0; k < 5; k++) send_beat(fb[k*DW +: DW], 1'b0);
        s_valid = 1'b1;
        s_data  = fb[5*DW +: DW];
        #2 rst = 1'b0;
        #1;
        check("midrst_work", work, 1'b0);
        check("midrst_tx", tx, '0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_occupancy", occupancy, 2'd0);
        check("midrst_s_ready", s_ready, 1'b1);
        exp_q.delete();
        tick();
        s_valid = 1'b0;
        tick();
        rst      = 1'b1;
        dec_free = 1'b1;
        n0 = work_cnt;
        for (int i = 0; i < 20; i++) tick();
        check("midrst_no_work", work_cnt, n0);
        check("midrst_occ_after", occupancy, 2'd0);
        send_frame(fc);
        wait_works(n0 + 1, 50, "midrst_new_frame_work");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, input beat width.
REQ-002 SHALL have parameter FRAME_W, default 256, codeword width; FRAME_W/DATA_W = BEATS (8), integer, checked at elaboration.
REQ-003 SHALL have parameter DEPTH, default 2, number of buffered complete frames.
REQ-004 SHALL have parameter BUSY_TO, default 4, cycles to wait for decoder acknowledge.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream beat valid.
REQ-008 s_data  input  DATA_W  upstream beat data.
REQ-009 s_last  input  1  marks final beat of a frame.
REQ-010 s_ready  output  1  beat accepted when s_valid and s_ready are both high at a clock edge.
REQ-011 dec_free  input  1  decoder free flag (idle, ready for work).
REQ-012 work  output  1  single-cycle start pulse to decoder.
REQ-013 tx  output  FRAME_W  codeword to decoder, registered.
REQ-014 frame_err  output  1  single-cycle pulse on framing error.
REQ-015 occupancy  output  clog2(DEPTH+1)  number of complete frames buffered.

Function
REQ-016 Beat k of a frame (k=0..BEATS-1) SHALL be written to assembly bits [DATA_W*k+DATA_W-1 : DATA_W*k]; beat 0 = LSBs.
REQ-017 Beat counter SHALL increment on each accepted beat and wrap to 0 after beat BEATS-1.
REQ-018 Frame SHALL be pushed into buffer on the edge accepting beat BEATS-1 with s_last=1.
REQ-019 s_last=1 on beat k<BEATS-1, or s_last=0 on beat BEATS-1: assembled beats SHALL be discarded, counter -> 0, nothing pushed, frame_err high for the following cycle.
REQ-020 s_ready SHALL be low only when counter = BEATS-1 and occupancy = DEPTH; independent of same-cycle pop.
REQ-021 Issue FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_FREE.
REQ-022 IDLE -> ISSUE when occupancy>0 and dec_free=1; ISSUE lasts one cycle with work=1 and tx = buffer head; head popped at end of ISSUE.
REQ-023 ISSUE -> WAIT_BUSY; WAIT_BUSY -> WAIT_FREE when dec_free=0; WAIT_BUSY -> IDLE after BUSY_TO cycles with dec_free still 1.
REQ-024 WAIT_FREE -> IDLE when dec_free=1.
REQ-025 tx SHALL hold its value from ISSUE until next ISSUE.
REQ-026 Minimum latency: final beat accepted at edge N (empty buffer, dec_free=1) -> work=1 during cycle after edge N+1.
REQ-027 Push and pop in same cycle SHALL leave occupancy unchanged; buffer FIFO order, no frame reordering or duplication.
REQ-028 work SHALL never be high on two consecutive cycles.

Reset
REQ-029 On rst low, immediately: work=0, tx=0, frame_err=0, occupancy=0, counter=0, FSM=IDLE, s_ready=1; buffer contents need not clear.
REQ-030 Reset asserted mid-frame or mid-issue SHALL discard all partial and buffered frames; no work pulse until a new complete frame arrives.

Structure
REQ-031 FRAME_W, DATA_W, BEATS and FSM state enumeration SHALL live in shared package ldpc_pkg, also used by the decoder.
REQ-032 Frame buffer SHALL be sub-module frame_fifo (DEPTH x FRAME_W, push/pop/count); assembly and FSM in frame_loader.

Verification
REQ-033 After reset, 8 beats 0x00000000..0x00000007 with s_last on beat 7, dec_free=1 -> one work pulse two cycles after beat 7, tx = 0x00000007_00000006_..._00000000.
REQ-034 s_last on beat 3 -> frame_err one cycle, no push, occupancy 0; next well-formed 8-beat frame issued normally.
REQ-035 dec_free=0 held, 3 frames streamed back-to-back -> occupancy reaches 2, s_ready low at counter=7; release dec_free -> frames issued in order, one per decoder free cycle.
REQ-036 Decoder model drops dec_free 1 cycle after work, raises 40 cycles later; 100 random frames -> 100 work pulses, tx sequence matches stimulus exactly.
REQ-037 dec_free stays 1 after work -> FSM returns to IDLE after 4 cycles, next buffered frame issued.
REQ-038 rst low at beat 5 with one frame buffered -> all outputs reset values asynchronously, occupancy 0, no work after release until 8 new beats.
